// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - CRC-9 constants and the 16-bit word checksum function
package crc_pkg;

  localparam int DATA_W = 16;
  localparam int CRC_W  = 9;
  localparam logic [CRC_W-1:0] CRC_POLY = 9'h133;

  // MSB-first shift of the message through the divisor: (data * x^9) mod G
  function automatic logic [CRC_W-1:0] crc9_16(input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] crc;
    logic             fb;
    crc = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = crc[CRC_W-1] ^ data[i];
      crc = {crc[CRC_W-2:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

endpackage

// File: rtl/crc9_engine.sv
// rtl/crc9_engine.sv - purely combinational 16->9 CRC XOR network
module crc9_engine
  import crc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  assign crc_o = crc9_16(data_i);

endmodule

// File: rtl/crc_req_arbiter.sv
// rtl/crc_req_arbiter.sv - round-robin sharing of one CRC-9 engine with a registered response
module crc_req_arbiter
  import crc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [CRC_W-1:0]            rsp_crc
);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CRC_W-1:0]  rsp_crc_q, rsp_crc_d;

  logic              can_accept;
  logic              gnt_found;
  logic              grant_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     scan_idx;
  logic [DATA_W-1:0] sel_data;
  logic [CRC_W-1:0]  sel_crc;

  assign can_accept = !rsp_valid_q || rsp_ready;

  // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      if (!gnt_found && req_valid[scan_idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign grant_any = gnt_found && can_accept && !rst;

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_data = req_data[gnt_idx*DATA_W +: DATA_W];

  crc9_engine u_crc9_engine (
    .data_i (sel_data),
    .crc_o  (sel_crc)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_crc_d   = rsp_crc_q;
    if (grant_any) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_data_d  = sel_data;
      rsp_crc_d   = sel_crc;
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_crc_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_crc_q   <= rsp_crc_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_crc   = rsp_crc_q;

endmodule

// File: tb/tb_crc_req_arbiter.sv
// tb/tb_crc_req_arbiter.sv - directed and randomized self-checking bench for crc_req_arbiter
module tb_crc_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 9;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic [CW-1:0]   rsp_crc;

  crc_req_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_crc   (rsp_crc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference response register and round-robin pointer
  int          m_ptr;
  logic        m_valid;
  int          m_id;
  logic [15:0] m_data;
  logic [8:0]  m_crc;
  int          last_g;

  // Long division of data*x^9 by the full 10-bit generator 0x333
  function automatic logic [8:0] ref_crc(input logic [15:0] d);
    logic [24:0] r;
    r = {d, 9'b0};
    for (int b = 24; b >= 9; b--)
      if (r[b]) r = r ^ (25'h333 << (b - 9));
    return r[8:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_data = '0; m_crc = '0;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  // Called just after a rising edge with inputs already applied
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int g;
    exp_rdy = '0;
    g = -1;
    if (!m_valid || rsp_ready)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g;
      m_data  = req_data[g*DW +: DW];
      m_crc   = ref_crc(m_data);
      m_ptr   = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    last_g = g;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    chk("rsp_crc",   32'(rsp_crc),   32'(m_crc));
  endtask

  initial begin
    int words;
    int budget;
    logic [N-1:0] held_rdy;

    rst = 1'b1;
    req_valid = 4'hF;
    req_data = '0;
    rsp_ready = 1'b1;
    last_g = -1;
    model_reset();
    set_word(0, 16'h0001);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id",    32'(rsp_id),    32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rsp_crc",   32'(rsp_crc),   32'h0);
    rst = 1'b0;
    req_valid = 4'h1;
    cycle();
    chk("first_grant", 32'(last_g), 32'd0);
    chk("crc_0001", 32'(rsp_crc), 32'h133);

    // Single-word CRCs from requester 0
    set_word(0, 16'h0002);
    cycle();
    chk("crc_0002", 32'(rsp_crc), 32'h155);
    set_word(0, 16'h0000);
    cycle();
    chk("crc_0000", 32'(rsp_crc), 32'h000);

    // Fairness with all requesters valid
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) set_word(i, 16'($urandom));
    for (int n = 0; n < 6; n++) begin
      cycle();
      chk("fair_order", 32'(last_g), 32'((1 + n) % N));
      chk("fair_no_bubble", 32'(rsp_valid), 32'h1);
      set_word(last_g, 16'($urandom));
    end

    // Backpressure with a response pending
    rsp_ready = 1'b0;
    for (int n = 0; n < 5; n++) cycle();
    rsp_ready = 1'b1;
    #1;
    held_rdy = req_ready;
    chk("bp_release_grant", 32'(|held_rdy), 32'h1);
    #1;
    cycle();
    chk("bp_release_id", 32'(rsp_id), 32'(3));

    // Sparse requests
    req_valid = 4'h0;
    cycle();
    req_valid = 4'h8;
    cycle();
    chk("sparse_last3", 32'(last_g), 32'd3);
    req_valid = 4'h4;
    cycle();
    chk("sparse_only2", 32'(last_g), 32'd2);
    req_valid = 4'hA;
    cycle();
    chk("sparse_3_first", 32'(last_g), 32'd3);
    req_valid = 4'h2;
    cycle();
    chk("sparse_then_1", 32'(last_g), 32'd1);

    // Reset while a response is pending
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'h0);
    chk("async_rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    req_valid = 4'hF;
    cycle();
    chk("post_rst_grant", 32'(last_g), 32'd0);

    // Randomized run; each requester holds its word until accepted
    words = (last_g >= 0) ? 1 : 0;
    req_valid[0] = 1'b0;
    budget = 0;
    while (words < 200 && budget < 4000) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && ($urandom_range(0, 99) < 60)) begin
          req_valid[i] = 1'b1;
          set_word(i, 16'($urandom));
        end
      rsp_ready = ($urandom_range(0, 99) < 70);
      cycle();
      if (last_g >= 0) begin
        words++;
        req_valid[last_g] = 1'b0;
      end
      budget++;
    end
    chk("rand_words", 32'(words), 32'd200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
